// File: rtl/tap_sequencer.sv
// FIR tap sequencer: circular sample history swept newest-to-oldest, one tap per handshake.
// Optional macro TAP_SEQUENCER_CLEAR_EN adds a synchronous history clear input clr_i.
module tap_sequencer #(
   parameter int DATA_WIDTH = 24,
   parameter int N_TAPS     = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
`ifdef TAP_SEQUENCER_CLEAR_EN
   input  logic                      clr_i,
`endif
   input  logic                      sample_valid_i,
   input  logic [DATA_WIDTH-1:0]     sample_i,
   output logic                      busy_o,
   output logic                      overrun_o,
   output logic                      tap_valid_o,
   input  logic                      tap_ready_i,
   output logic [DATA_WIDTH-1:0]     tap_data_o,
   output logic [$clog2(N_TAPS)-1:0] tap_idx_o,
   output logic                      tap_last_o
);

   localparam int IW = $clog2(N_TAPS);
   localparam logic [IW-1:0] LAST_IDX = IW'(N_TAPS - 1);
   localparam logic [IW:0]   N_EXT    = (IW + 1)'(N_TAPS);

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t                state;
   logic [IW-1:0]         wr_ptr;
   logic [DATA_WIDTH-1:0] mem [N_TAPS];
   logic [IW-1:0]         next_k;
   logic [IW-1:0]         rd_addr;
   logic [IW-1:0]         next_wr;

   assign busy_o = (state == SWEEP);

   // Next tap index and its history address (wr_ptr - k) mod N_TAPS, safe for non-power-of-two depths
   always_comb begin
      next_k = tap_idx_o + IW'(1);
      if (wr_ptr >= next_k) begin
         rd_addr = wr_ptr - next_k;
      end else begin
         rd_addr = IW'(({1'b0, wr_ptr} + N_EXT) - {1'b0, next_k});
      end
      if (wr_ptr == LAST_IDX) begin
         next_wr = {IW{1'b0}};
      end else begin
         next_wr = wr_ptr + IW'(1);
      end
   end

   // Sequencer FSM, history storage and registered tap outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= IDLE;
         wr_ptr      <= {IW{1'b0}};
         mem         <= '{default: {DATA_WIDTH{1'b0}}};
         overrun_o   <= 1'b0;
         tap_valid_o <= 1'b0;
         tap_data_o  <= {DATA_WIDTH{1'b0}};
         tap_idx_o   <= {IW{1'b0}};
         tap_last_o  <= 1'b0;
      end else
`ifdef TAP_SEQUENCER_CLEAR_EN
      if (clr_i) begin
         state       <= IDLE;
         wr_ptr      <= {IW{1'b0}};
         mem         <= '{default: {DATA_WIDTH{1'b0}}};
         overrun_o   <= 1'b0;
         tap_valid_o <= 1'b0;
         tap_data_o  <= {DATA_WIDTH{1'b0}};
         tap_idx_o   <= {IW{1'b0}};
         tap_last_o  <= 1'b0;
      end else
`endif
      begin
         case (state)
            IDLE: begin
               overrun_o <= 1'b0;
               if (sample_valid_i) begin
                  // Tap 0 is the sample itself, so forward it rather than read it back
                  mem[wr_ptr] <= sample_i;
                  state       <= SWEEP;
                  tap_valid_o <= 1'b1;
                  tap_data_o  <= sample_i;
                  tap_idx_o   <= {IW{1'b0}};
                  tap_last_o  <= 1'b0;
               end
            end
            SWEEP: begin
               overrun_o <= sample_valid_i;
               if (tap_ready_i) begin
                  if (tap_idx_o == LAST_IDX) begin
                     state       <= IDLE;
                     wr_ptr      <= next_wr;
                     tap_valid_o <= 1'b0;
                     tap_last_o  <= 1'b0;
                  end else begin
                     tap_idx_o  <= next_k;
                     tap_data_o <= mem[rd_addr];
                     tap_last_o <= (next_k == LAST_IDX);
                  end
               end
            end
            default: begin
               state       <= IDLE;
               overrun_o   <= 1'b0;
               tap_valid_o <= 1'b0;
               tap_last_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tap_sequencer.sv
// Directed bench for tap_sequencer with N_TAPS=4; clear scenario built when TAP_SEQUENCER_CLEAR_EN is defined.
module tb_tap_sequencer;

   logic        clk_i = 1'b0;
   logic        rst_ni;
`ifdef TAP_SEQUENCER_CLEAR_EN
   logic        clr_i = 1'b0;
`endif
   logic        sample_valid_i;
   logic [23:0] sample_i;
   logic        busy_o;
   logic        overrun_o;
   logic        tap_valid_o;
   logic        tap_ready_i;
   logic [23:0] tap_data_o;
   logic [1:0]  tap_idx_o;
   logic        tap_last_o;

   int checks = 0;
   int passed = 0;

   tap_sequencer #(.DATA_WIDTH(24), .N_TAPS(4)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
`ifdef TAP_SEQUENCER_CLEAR_EN
      .clr_i          (clr_i),
`endif
      .sample_valid_i (sample_valid_i),
      .sample_i       (sample_i),
      .busy_o         (busy_o),
      .overrun_o      (overrun_o),
      .tap_valid_o    (tap_valid_o),
      .tap_ready_i    (tap_ready_i),
      .tap_data_o     (tap_data_o),
      .tap_idx_o      (tap_idx_o),
      .tap_last_o     (tap_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic accept(input logic [23:0] v);
      sample_valid_i = 1'b1;
      sample_i       = v;
      tick();
      sample_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; sample_valid_i = 1'b0; sample_i = 24'd0; tap_ready_i = 1'b1;
      #12;
      checks++;
      if ({busy_o, overrun_o, tap_valid_o, tap_last_o} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {busy_o, overrun_o, tap_valid_o, tap_last_o});
      else passed++;
      checks++;
      if ({tap_data_o, tap_idx_o} !== 26'd0)
         $display("FAIL reset_data_idx: got data %0d idx %0d expected 0 0", tap_data_o, tap_idx_o);
      else passed++;
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_first_sweep();
      logic [23:0] exp [4] = '{24'd5, 24'd0, 24'd0, 24'd0};
      accept(24'd5);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({busy_o, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o} !== {1'b1, 1'b1, (i == 3), i[1:0], exp[i]})
            $display("FAIL first_sweep tap%0d: got v=%b l=%b idx=%0d data=%0d expected v=1 l=%b idx=%0d data=%0d",
                     i, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o, (i == 3), i, exp[i]);
         else passed++;
         tick();
      end
      checks++;
      if ({busy_o, tap_valid_o} !== 2'b00)
         $display("FAIL first_sweep_idle: got busy=%b valid=%b expected 0 0", busy_o, tap_valid_o);
      else passed++;
   endtask

   task automatic test_wrap();
      logic [23:0] exp [4] = '{24'd6, 24'd5, 24'd4, 24'd3};
      for (int s = 1; s <= 5; s++) begin
         accept(24'(s));
         repeat (4) tick();
      end
      accept(24'd6);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tap_valid_o, tap_last_o, tap_idx_o, tap_data_o} !== {1'b1, (i == 3), i[1:0], exp[i]})
            $display("FAIL wrap tap%0d: got v=%b l=%b idx=%0d data=%0d expected v=1 l=%b idx=%0d data=%0d",
                     i, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o, (i == 3), i, exp[i]);
         else passed++;
         tick();
      end
      checks++;
      if (busy_o !== 1'b0)
         $display("FAIL wrap_throughput: got busy=%b expected 0", busy_o);
      else passed++;
   endtask

   task automatic test_stall();
      accept(24'd7);
      tick();
      tick();
      tap_ready_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({tap_valid_o, tap_last_o, tap_idx_o, tap_data_o} !== {1'b1, 1'b0, 2'd2, 24'd5})
            $display("FAIL stall_hold cyc%0d: got v=%b l=%b idx=%0d data=%0d expected v=1 l=0 idx=2 data=5",
                     c, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o);
         else passed++;
      end
      tap_ready_i = 1'b1;
      tick();
      checks++;
      if ({tap_valid_o, tap_last_o, tap_idx_o, tap_data_o} !== {1'b1, 1'b1, 2'd3, 24'd4})
         $display("FAIL stall_resume: got v=%b l=%b idx=%0d data=%0d expected v=1 l=1 idx=3 data=4",
                  tap_valid_o, tap_last_o, tap_idx_o, tap_data_o);
      else passed++;
      tick();
   endtask

   task automatic test_overrun();
      logic [23:0] exp [4] = '{24'd9, 24'd8, 24'd7, 24'd6};
      accept(24'd8);
      sample_valid_i = 1'b1; sample_i = 24'd99;
      tick();
      sample_valid_i = 1'b0;
      checks++;
      if ({overrun_o, tap_idx_o} !== {1'b1, 2'd1})
         $display("FAIL overrun_mid: got ovr=%b idx=%0d expected ovr=1 idx=1", overrun_o, tap_idx_o);
      else passed++;
      tick();
      checks++;
      if (overrun_o !== 1'b0)
         $display("FAIL overrun_pulse_width: got %b expected 0", overrun_o);
      else passed++;
      tick();
      sample_valid_i = 1'b1; sample_i = 24'd77;
      tick();
      sample_valid_i = 1'b0;
      checks++;
      if ({overrun_o, tap_valid_o, busy_o} !== 3'b100)
         $display("FAIL overrun_last: got ovr=%b valid=%b busy=%b expected 1 0 0", overrun_o, tap_valid_o, busy_o);
      else passed++;
      tick();
      checks++;
      if ({overrun_o, tap_valid_o} !== 2'b00)
         $display("FAIL overrun_idle: got ovr=%b valid=%b expected 0 0", overrun_o, tap_valid_o);
      else passed++;
      accept(24'd9);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tap_valid_o, tap_idx_o, tap_data_o} !== {1'b1, i[1:0], exp[i]})
            $display("FAIL overrun_next tap%0d: got v=%b idx=%0d data=%0d expected v=1 idx=%0d data=%0d",
                     i, tap_valid_o, tap_idx_o, tap_data_o, i, exp[i]);
         else passed++;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      accept(24'd10);
      tick();
      #2;
      rst_ni = 1'b0;
      #1;
      checks++;
      if ({busy_o, overrun_o, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o} !== 30'd0)
         $display("FAIL reset_mid_async: got busy=%b ovr=%b v=%b l=%b idx=%0d data=%0d expected all 0",
                  busy_o, overrun_o, tap_valid_o, tap_last_o, tap_idx_o, tap_data_o);
      else passed++;
      tick();
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy_o, tap_valid_o} !== 2'b00)
         $display("FAIL reset_mid_no_partial: got busy=%b valid=%b expected 0 0", busy_o, tap_valid_o);
      else passed++;
      accept(24'd11);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tap_valid_o, tap_idx_o, tap_data_o} !== {1'b1, i[1:0], (i == 0) ? 24'd11 : 24'd0})
            $display("FAIL reset_mid_sweep tap%0d: got v=%b idx=%0d data=%0d expected v=1 idx=%0d data=%0d",
                     i, tap_valid_o, tap_idx_o, tap_data_o, i, (i == 0) ? 11 : 0);
         else passed++;
         tick();
      end
   endtask

`ifdef TAP_SEQUENCER_CLEAR_EN
   task automatic test_clear();
      clr_i = 1'b1; sample_valid_i = 1'b1; sample_i = 24'd55;
      tick();
      clr_i = 1'b0; sample_valid_i = 1'b0;
      checks++;
      if ({busy_o, tap_valid_o} !== 2'b00)
         $display("FAIL clear_drop: got busy=%b valid=%b expected 0 0", busy_o, tap_valid_o);
      else passed++;
      accept(24'd12);
      tick();
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      checks++;
      if ({busy_o, tap_valid_o} !== 2'b00)
         $display("FAIL clear_abort: got busy=%b valid=%b expected 0 0", busy_o, tap_valid_o);
      else passed++;
      accept(24'd13);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({tap_valid_o, tap_idx_o, tap_data_o} !== {1'b1, i[1:0], (i == 0) ? 24'd13 : 24'd0})
            $display("FAIL clear_sweep tap%0d: got v=%b idx=%0d data=%0d expected v=1 idx=%0d data=%0d",
                     i, tap_valid_o, tap_idx_o, tap_data_o, i, (i == 0) ? 13 : 0);
         else passed++;
         tick();
      end
   endtask
`endif

   initial begin
      test_reset();
      test_first_sweep();
      test_wrap();
      test_stall();
      test_overrun();
      test_reset_mid();
`ifdef TAP_SEQUENCER_CLEAR_EN
      test_clear();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
